alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the combinational 32-bit ALU.
- Executes the same 16-instruction set on WIDTH-bit operands and adds status flags (zero, carry, overflow, negative).
- Uses valid/ready handshakes on input and output, so it sits between an issue queue and a writeback stage that may apply backpressure.
- Keeps a saturating count of retired operations for performance monitoring.

---
 rtl/alu_pipe.sv | 180 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, status flags and a
// saturating retired-operation counter.
module alu_pipe #(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_CMP = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       INST,
    input  logic             SEL,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic [3:0]       FLAGS,
    output logic [CNT_W-1:0] OPS_DONE
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_NEGA  = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_INVA  = 4'h5,
        OP_SELBA = 4'h6,
        OP_SELAB = 4'h7,
        OP_SUB   = 4'h8,
        OP_LT    = 4'h9,
        OP_LE    = 4'hA,
        OP_GT    = 4'hB,
        OP_GE    = 4'hC,
        OP_EQ    = 4'hD,
        OP_NE    = 4'hE,
        OP_SELB0 = 4'hF
    } op_e;

    // Stage 1 registers
    logic             s1_v_q,   s1_v_d;
    logic [WIDTH-1:0] s1_a_q,   s1_a_d;
    logic [WIDTH-1:0] s1_b_q,   s1_b_d;
    op_e              s1_op_q,  s1_op_d;
    logic             s1_sel_q, s1_sel_d;

    // Stage 2 registers
    logic             s2_v_q,   s2_v_d;
    logic [WIDTH-1:0] z_q,      z_d;
    logic [3:0]       flags_q,  flags_d;
    logic [CNT_W-1:0] ops_q,    ops_d;

    logic             s1_adv;
    logic             s2_adv;

    // Datapath on stage-1 contents
    logic             sub_like;
    logic             is_arith;
    logic             is_cmp;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic [WIDTH:0]   sum_ext;
    logic             carry;
    logic             ovf;
    logic             lt;
    logic             eq;
    logic [WIDTH-1:0] res;
    logic [3:0]       flags_nxt;

    always_comb begin
        sub_like = s1_op_q inside {OP_NEGA, OP_SUB, OP_LT, OP_LE, OP_GT, OP_GE, OP_EQ, OP_NE};
        is_arith = s1_op_q inside {OP_ADD, OP_NEGA, OP_SUB};
        is_cmp   = s1_op_q inside {OP_LT, OP_LE, OP_GT, OP_GE, OP_EQ, OP_NE};

        // NEGA is computed as 0 + ~A + 1 so it shares the subtract carry chain
        add_x   = (s1_op_q == OP_NEGA) ? '0 : s1_a_q;
        add_y   = (s1_op_q == OP_NEGA) ? ~s1_a_q : (sub_like ? ~s1_b_q : s1_b_q);
        sum_ext = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, sub_like};
        carry   = sum_ext[WIDTH];
        ovf     = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum_ext[WIDTH-1] != add_x[WIDTH-1]);

        if (SIGNED_CMP) lt = sum_ext[WIDTH-1] ^ ovf;
        else            lt = ~carry;
        eq = (s1_a_q == s1_b_q);

        res = '0;
        case (s1_op_q)
            OP_ADD:   res = sum_ext[WIDTH-1:0];
            OP_NEGA:  res = sum_ext[WIDTH-1:0];
            OP_AND:   res = s1_a_q & s1_b_q;
            OP_OR:    res = s1_a_q | s1_b_q;
            OP_XOR:   res = s1_a_q ^ s1_b_q;
            OP_INVA:  res = ~s1_a_q;
            OP_SELBA: res = s1_sel_q ? s1_b_q : s1_a_q;
            OP_SELAB: res = s1_sel_q ? s1_a_q : s1_b_q;
            OP_SUB:   res = sum_ext[WIDTH-1:0];
            OP_LT:    res[0] = lt;
            OP_LE:    res[0] = lt | eq;
            OP_GT:    res[0] = ~(lt | eq);
            OP_GE:    res[0] = ~lt;
            OP_EQ:    res[0] = eq;
            OP_NE:    res[0] = ~eq;
            OP_SELB0: res[0] = s1_sel_q ^ s1_b_q[0];
        endcase

        flags_nxt = {res[WIDTH-1],
                     is_arith & ovf,
                     (is_arith | is_cmp) & carry,
                     (res == '0)};
    end

    // Handshake and next-state
    always_comb begin
        s2_adv   = !s2_v_q || out_ready;
        s1_adv   = !s1_v_q || s2_adv;

        s1_v_d   = s1_v_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_op_d  = s1_op_q;
        s1_sel_d = s1_sel_q;
        s2_v_d   = s2_v_q;
        z_d      = z_q;
        flags_d  = flags_q;
        ops_d    = ops_q;

        if (s1_adv) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_a_d   = A;
                s1_b_d   = B;
                s1_op_d  = op_e'(INST);
                s1_sel_d = SEL;
            end
        end

        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                z_d     = res;
                flags_d = flags_nxt;
            end
        end

        if (s2_v_q && out_ready && (ops_q != '1)) ops_d = ops_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_op_q  <= OP_ADD;
            s1_sel_q <= 1'b0;
            s2_v_q   <= 1'b0;
            z_q      <= '0;
            flags_q  <= '0;
            ops_q    <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_op_q  <= s1_op_d;
            s1_sel_q <= s1_sel_d;
            s2_v_q   <= s2_v_d;
            z_q      <= z_d;
            flags_q  <= flags_d;
            ops_q    <= ops_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_v_q;
    assign Z         = z_q;
    assign FLAGS     = flags_q;
    assign OPS_DONE  = ops_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: latency, opcode stream (signed/unsigned),
// backpressure, mid-stall reset, counter saturation, and an 8-bit model run.
module tb_alu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv, orr, sel;
    logic [31:0] a, b;
    logic [3:0]  inst;

    logic        m_ir, m_ov;  logic [31:0] m_z;  logic [3:0] m_f;  logic [15:0] m_ops;
    logic        u_ir, u_ov;  logic [31:0] u_z;  logic [3:0] u_f;  logic [15:0] u_ops;
    logic        c_ir, c_ov;  logic [31:0] c_z;  logic [3:0] c_f;  logic [1:0]  c_ops;

    logic        w_iv, w_ir, w_or, w_sel, w_ov;
    logic [7:0]  w_a, w_b, w_z;
    logic [3:0]  w_inst, w_f;
    logic [15:0] w_ops;

    alu_pipe #(.WIDTH(32), .SIGNED_CMP(1'b1), .CNT_W(16)) dut_m (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(m_ir), .A(a), .B(b), .INST(inst), .SEL(sel),
        .out_valid(m_ov), .out_ready(orr), .Z(m_z), .FLAGS(m_f), .OPS_DONE(m_ops));

    alu_pipe #(.WIDTH(32), .SIGNED_CMP(1'b0), .CNT_W(16)) dut_u (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(u_ir), .A(a), .B(b), .INST(inst), .SEL(sel),
        .out_valid(u_ov), .out_ready(orr), .Z(u_z), .FLAGS(u_f), .OPS_DONE(u_ops));

    alu_pipe #(.WIDTH(32), .SIGNED_CMP(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(c_ir), .A(a), .B(b), .INST(inst), .SEL(sel),
        .out_valid(c_ov), .out_ready(orr), .Z(c_z), .FLAGS(c_f), .OPS_DONE(c_ops));

    alu_pipe #(.WIDTH(8), .SIGNED_CMP(1'b1), .CNT_W(16)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_iv), .in_ready(w_ir), .A(w_a), .B(w_b), .INST(w_inst), .SEL(w_sel),
        .out_valid(w_ov), .out_ready(w_or), .Z(w_z), .FLAGS(w_f), .OPS_DONE(w_ops));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        iv   = 1'b0;  orr  = 1'b1;
        w_iv = 1'b0;  w_or = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Latency counts the accepting edge as 1; out_valid must rise on edge 2.
    task automatic one_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic s, input logic [31:0] ez, input logic [3:0] ef);
        int lat;
        iv = 1'b1; inst = op; a = av; b = bv; sel = s; orr = 1'b1;
        tick();
        iv  = 1'b0;
        lat = 1;
        while (!m_ov && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd2);
        check({tag, " z"}, 64'(m_z), 64'(ez));
        check({tag, " flags"}, 64'(m_f), 64'(ef));
        tick();
    endtask

    // Expected stream for A=FFFFFFFF, B=1, SEL=1 (signed compares); flags {N,V,C,Zf}
    logic [31:0] ez_s [16] = '{32'h0, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'h1, 32'hFFFFFFFF,
                               32'hFFFFFFFE, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0};
    logic [3:0]  ef_s [16] = '{4'b0011, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0001, 4'b0000, 4'b1000,
                               4'b1010, 4'b0010, 4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0001};
    logic [31:0] ez_u [16] = '{32'h0, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'h1, 32'hFFFFFFFF,
                               32'hFFFFFFFE, 32'h0, 32'h0, 32'h1, 32'h1, 32'h0, 32'h1, 32'h0};

    function automatic logic [11:0] model8(input logic [3:0] op, input logic [7:0] x,
                                           input logic [7:0] y, input logic s);
        logic [7:0] z;
        logic [8:0] t;
        logic       c, v;
        int         sx, sy, r;
        sx = $signed(x);
        sy = $signed(y);
        z = 8'h00; c = 1'b0; v = 1'b0;
        case (op)
            4'h0: begin t = {1'b0, x} + {1'b0, y}; z = t[7:0]; c = t[8]; r = sx + sy; v = (r > 127) || (r < -128); end
            4'h1: begin z = 8'h00 - x; c = (x == 8'h00); v = (x == 8'h80); end
            4'h2: z = x & y;
            4'h3: z = x | y;
            4'h4: z = x ^ y;
            4'h5: z = ~x;
            4'h6: z = s ? y : x;
            4'h7: z = s ? x : y;
            4'h8: begin z = x - y; c = (x >= y); r = sx - sy; v = (r > 127) || (r < -128); end
            4'h9: begin z = {7'b0, sx <  sy}; c = (x >= y); end
            4'hA: begin z = {7'b0, sx <= sy}; c = (x >= y); end
            4'hB: begin z = {7'b0, sx >  sy}; c = (x >= y); end
            4'hC: begin z = {7'b0, sx >= sy}; c = (x >= y); end
            4'hD: begin z = {7'b0, x == y};   c = (x >= y); end
            4'hE: begin z = {7'b0, x != y};   c = (x >= y); end
            default: z = {7'b0, s ^ y[0]};
        endcase
        return {z[7], v, c, (z == 8'h00), z};
    endfunction

    initial begin
        logic [11:0] q[$];
        logic [11:0] e;
        int acc, cyc;

        a = '0; b = '0; inst = '0; sel = 1'b0;
        w_a = '0; w_b = '0; w_inst = '0; w_sel = 1'b0;
        do_reset();

        check("rst out_valid", 64'(m_ov), 64'd0);
        check("rst z", 64'(m_z), 64'd0);
        check("rst flags", 64'(m_f), 64'd0);
        check("rst ops", 64'(m_ops), 64'd0);
        check("rst in_ready", 64'(m_ir), 64'd1);

        one_op("add ovf", 4'h0, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 4'b1100);
        one_op("nega min", 4'h1, 32'h80000000, 32'h0, 1'b0, 32'h80000000, 4'b1100);
        one_op("sub 5-5", 4'h8, 32'h5, 32'h5, 1'b0, 32'h0, 4'b0011);

        // Back-to-back all opcodes; result k-2 visible in iteration k
        do_reset();
        for (int k = 0; k < 19; k++) begin
            if (k < 16) begin
                iv = 1'b1; inst = 4'(k); a = 32'hFFFFFFFF; b = 32'h1; sel = 1'b1;
            end else begin
                iv = 1'b0;
            end
            if (k >= 2 && k <= 17) begin
                check($sformatf("stream%0d valid", k-2), 64'(m_ov), 64'd1);
                check($sformatf("stream%0d z", k-2), 64'(m_z), 64'(ez_s[k-2]));
                check($sformatf("stream%0d flags", k-2), 64'(m_f), 64'(ef_s[k-2]));
                check($sformatf("ustream%0d z", k-2), 64'(u_z), 64'(ez_u[k-2]));
            end
            if (k >= 3) begin
                check($sformatf("ops%0d", k), 64'(m_ops), 64'(k-2));
                check($sformatf("sat ops%0d", k), 64'(c_ops), 64'((k-2 > 3) ? 3 : k-2));
            end
            tick();
        end
        check("stream idle", 64'(m_ov), 64'd0);

        // Backpressure with a full pipe, then simultaneous in/out transfer
        do_reset();
        orr = 1'b0;
        iv = 1'b1; inst = 4'h0; a = 32'h1; b = 32'h2; sel = 1'b0;
        tick();
        inst = 4'h8; a = 32'h9; b = 32'h4;
        check("bp ready s2 empty", 64'(m_ir), 64'd1);
        tick();
        iv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp in_ready", 64'(m_ir), 64'd0);
            check("bp out_valid", 64'(m_ov), 64'd1);
            check("bp z hold", 64'(m_z), 64'h3);
            check("bp flags hold", 64'(m_f), 64'd0);
            tick();
        end
        orr = 1'b1; iv = 1'b1; inst = 4'h2; a = 32'hF0; b = 32'h3C;
        #1;
        check("bp release ready", 64'(m_ir), 64'd1);
        check("bp drain0 z", 64'(m_z), 64'h3);
        tick();
        iv = 1'b0;
        check("bp drain1 valid", 64'(m_ov), 64'd1);
        check("bp drain1 z", 64'(m_z), 64'h5);
        check("bp drain1 flags", 64'(m_f), 64'b0010);
        tick();
        check("bp drain2 valid", 64'(m_ov), 64'd1);
        check("bp drain2 z", 64'(m_z), 64'h30);
        tick();
        check("bp empty", 64'(m_ov), 64'd0);

        // Asynchronous reset while stalled with two ops in flight
        orr = 1'b0;
        iv = 1'b1; inst = 4'h0; a = 32'h1; b = 32'h1;
        tick();
        a = 32'h2; b = 32'h2;
        tick();
        iv = 1'b0;
        check("pre-rst valid", 64'(m_ov), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid rst valid", 64'(m_ov), 64'd0);
        check("mid rst z", 64'(m_z), 64'd0);
        check("mid rst flags", 64'(m_f), 64'd0);
        check("mid rst ops", 64'(m_ops), 64'd0);
        tick();
        rst = 1'b0; orr = 1'b1;
        check("post rst ready", 64'(m_ir), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post rst no stale", 64'(m_ov), 64'd0);
        end

        // 8-bit instance against the reference model with random backpressure
        do_reset();
        acc = 0;
        cyc = 0;
        while ((acc < 1000 || q.size() != 0) && cyc < 20000) begin
            w_or = ($urandom_range(0, 3) != 0);
            if (acc < 1000) begin
                w_iv   = 1'($urandom_range(0, 1));
                w_a    = 8'($urandom_range(0, 255));
                w_b    = 8'($urandom_range(0, 255));
                w_inst = 4'($urandom_range(0, 15));
                w_sel  = 1'($urandom_range(0, 1));
            end else begin
                w_iv = 1'b0;
            end
            #1;
            if (w_iv && w_ir) begin
                q.push_back(model8(w_inst, w_a, w_b, w_sel));
                acc++;
            end
            if (w_ov && w_or) begin
                if (q.size() == 0) begin
                    check("w8 spurious result", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("w8 z", 64'(w_z), 64'(e[7:0]));
                    check("w8 flags", 64'(w_f), 64'(e[11:8]));
                end
            end
            tick();
            cyc++;
        end
        check("w8 accepted", 64'(acc), 64'd1000);
        check("w8 drained", 64'(q.size()), 64'd0);
        check("w8 ops", 64'(w_ops), 64'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
